// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed, XOR-checksummed byte stream and
// writes little-endian words to imem from address 0. The core stays in reset until the image is verified.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN_LO  | waiting for the low byte of the word count
// LEN_HI  | waiting for the high byte; range-checks the count
// DATA    | collecting payload bytes into the current word
// WRITE   | one-cycle imem write of the assembled word
// CHECK   | waiting for the checksum byte
// DONE    | image verified, core released
// ERR     | load aborted, core held in reset
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  // Wide enough to hold both the 16-bit length and the ADDR_W+1 word counter.
  localparam int CW = ADDR_W + 17;

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] word_cnt;
  logic [15:0]     len;
  logic [7:0]      csum;
  logic [31:0]     shreg;
  logic [31:0]     shreg_next;
  logic [15:0]     len_next;
  logic [ADDR_W:0] word_inc;
  logic            accept;

  assign accept   = byte_valid && byte_ready;
  assign len_next = {byte_in, len[7:0]};
  assign word_inc = word_cnt + 1'b1;

  always_comb begin
    shreg_next = shreg;
    shreg_next[{byte_cnt, 3'b000} +: 8] = byte_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      len         <= '0;
      csum        <= '0;
      shreg       <= '0;
      byte_ready  <= 1'b0;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state       <= S_LEN_LO;
            byte_ready  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
            word_cnt    <= '0;
            byte_cnt    <= '0;
            csum        <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_in;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len <= len_next;
            if (CW'(len_next) > (CW'(1) << ADDR_W)) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            shreg    <= shreg_next;
            csum     <= csum ^ byte_in;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              imem_we    <= 1'b1;
              imem_waddr <= word_cnt[ADDR_W-1:0];
              imem_wdata <= shreg_next;
            end
          end
        end
        S_WRITE: begin
          word_cnt   <= word_inc;
          byte_ready <= 1'b1;
          state      <= (CW'(word_inc) == CW'(len)) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_in == csum) begin
              state       <= S_DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole frames plus hand-written
// sequences for backpressure, a maximum-length image and reset mid-load.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset_n;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_reset_n(cpu_reset_n),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Write log: every cycle with imem_we high is one entry.
  int          wr_n = 0;
  logic [31:0] wa [0:4095];
  logic [31:0] wd [0:4095];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_n < 4096) begin
        wa[wr_n] = 32'(imem_waddr);
        wd[wr_n] = imem_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  typedef struct {
    string       name;
    logic [87:0] stream;  // first byte in bits [7:0]
    int          nb;
    int          nwr;
    logic [31:0] a0, d0, a1, d1;
    logic        done_e, err_e;
  } rec_t;

  rec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL handshake_timeout: byte_ready stayed %b, required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_rec(input rec_t r);
    int base;
    base = wr_n;
    pulse_start();
    check({r.name, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < r.nb; i++) send(r.stream[8*i +: 8], 0);
    check({r.name, "_done"}, 32'(done), 32'(r.done_e));
    check({r.name, "_error"}, 32'(error), 32'(r.err_e));
    check({r.name, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(r.done_e));
    check({r.name, "_busy_end"}, 32'(busy), 32'd0);
    check({r.name, "_byte_ready"}, 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    check({r.name, "_nwrites"}, 32'(wr_n - base), 32'(r.nwr));
    if (r.nwr >= 1 && wr_n - base >= 1) begin
      check({r.name, "_addr0"}, wa[base], r.a0);
      check({r.name, "_data0"}, wd[base], r.d0);
    end
    if (r.nwr >= 2 && wr_n - base >= 2) begin
      check({r.name, "_addr1"}, wa[base+1], r.a1);
      check({r.name, "_data1"}, wd[base+1], r.d1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] frame [11];
    logic [7:0] cs;

    tbl[0] = '{"two_word", 88'hB0_00_20_05_93_00_10_05_13_00_02, 11, 2,
               32'd0, 32'h00100513, 32'd1, 32'h00200593, 1'b1, 1'b0};
    tbl[1] = '{"one_word", 88'h22_DE_AD_BE_EF_00_01, 7, 1,
               32'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b1, 1'b0};
    tbl[2] = '{"zero_len", 88'h00_00_00, 3, 0,
               32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0};
    tbl[3] = '{"bad_csum", 88'hB1_00_20_05_93_00_10_05_13_00_02, 11, 2,
               32'd0, 32'h00100513, 32'd1, 32'h00200593, 1'b0, 1'b1};
    tbl[4] = '{"oversize", 88'h04_01, 2, 0,
               32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};

    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_rec(tbl[t]);

    // Oversize wrote nothing, so the bad-checksum frame's last write must still be visible.
    check("hold_waddr", 32'(imem_waddr), 32'd1);
    check("hold_wdata", imem_wdata, 32'h00200593);

    // Backpressure with a start pulse in the middle of DATA.
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    base = wr_n;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      if (i == 4) begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(frame[i], 1);
      end else begin
        send(frame[i], 3);
      end
    end
    repeat (3) @(negedge clk);
    check("bp_nwrites", 32'(wr_n - base), 32'd2);
    check("bp_addr0", wa[base], 32'd0);
    check("bp_data0", wd[base], 32'h00100513);
    check("bp_addr1", wa[base+1], 32'd1);
    check("bp_data1", wd[base+1], 32'h00200593);
    check("bp_done", 32'(done), 32'd1);
    check("bp_cpu_reset_n", 32'(cpu_reset_n), 32'd1);

    // Largest legal image: N = 2**ADDR_W, word i holds value i.
    base = wr_n;
    cs = 8'h00;
    pulse_start();
    send(8'h00, 0);
    send(8'h04, 0);
    for (int w = 0; w < 1024; w++) begin
      logic [15:0] wv;
      wv = 16'(w);
      send(wv[7:0], 0);
      send(wv[15:8], 0);
      send(8'h00, 0);
      send(8'h00, 0);
      cs = cs ^ wv[7:0] ^ wv[15:8];
    end
    send(cs, 0);
    repeat (2) @(negedge clk);
    check("max_nwrites", 32'(wr_n - base), 32'd1024);
    check("max_first_addr", wa[base], 32'd0);
    check("max_last_addr", wa[base+1023], 32'd1023);
    check("max_last_data", wd[base+1023], 32'd1023);
    check("max_done", 32'(done), 32'd1);
    check("max_error", 32'(error), 32'd0);

    // Reset after two payload bytes, then a full load.
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h05, 0);
    base = wr_n;
    reset_n = 1'b0;
    #1;
    check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_waddr", 32'(imem_waddr), 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_flags", {28'd0, cpu_reset_n, busy, done, error}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_write", 32'(wr_n - base), 32'd0);
    run_rec(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU instruction memory. The CPU core only reads imem; this block fills it.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes them to consecutive imem word addresses starting at 0.
- Holds the core in reset via cpu_reset_n until a complete, checksum-verified image is loaded.
- Sits in top between the external load port and the imem write port and core reset.

Parameters:
- ADDR_W, 10, imem word-address width; imem depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins a new load from IDLE, DONE or ERR
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in is valid this cycle
- byte_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  imem write strobe, one cycle per word
- imem_waddr  output  ADDR_W  imem word address
- imem_wdata  output  32  assembled instruction word
- cpu_reset_n  output  1  active-low reset to the CPU core
- busy  output  1  load in progress
- done  output  1  image loaded and verified
- error  output  1  load aborted

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE.
  - byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - cpu_reset_n=0, busy=0, done=0, error=0.
  - Internal byte counter, word counter, length and checksum all cleared.
  - Applies mid-load with no completion of a partial word.
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N payload bytes, each word least-significant byte first.
  - One checksum byte equal to the XOR of all payload bytes.
- Handshake: a byte is accepted only in a cycle where byte_valid && byte_ready. Gaps in byte_valid stall the FSM with no state change.
- byte_ready is registered. It is 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 in all other states and in the WRITE cycle.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR.
- IDLE / DONE / ERR + start -> LEN_LO.
  - On entry: cpu_reset_n=0, done=0, error=0, busy=1.
  - Word counter, byte counter and checksum cleared to 0.
- start in any other state is ignored.
- LEN_LO + accept -> LEN_HI.
- LEN_HI + accept: N = {byte,lo}, then:
  - N > 2**ADDR_W -> ERR.
  - N == 0 -> CHECK.
  - otherwise -> DATA.
- DATA + accept:
  - Shift the byte into the word shift register at position byte_cnt.
  - checksum ^= byte; byte_cnt++ (2 bits, wraps).
  - On the 4th byte -> WRITE.
- WRITE lasts exactly one cycle:
  - imem_we=1, imem_waddr = word counter[ADDR_W-1:0], imem_wdata = assembled word.
  - Word counter (ADDR_W+1 bits) increments.
  - If the incremented count == N -> CHECK, else -> DATA.
- Write latency: imem_we is asserted in the cycle after the 4th-byte handshake.
- CHECK + accept:
  - byte == checksum -> DONE.
  - otherwise -> ERR.
- DONE: busy=0, done=1, cpu_reset_n=1, held until reset or start.
- ERR: busy=0, error=1, cpu_reset_n=0, held until reset or start.
- Outside WRITE: imem_we=0. imem_waddr and imem_wdata hold their last values.
- N = 2**ADDR_W is legal. The last write is at address 2**ADDR_W-1, and the word counter must not wrap before comparison.
- All outputs are registered.

Test Plan:
- Two-word load:
  - Stimulus: start, then bytes 02 00 | 13 05 10 00 | 93 05 20 00 | checksum.
  - Checksum = XOR of payload = 0x13^0x05^0x10^0x93^0x05^0x20 = 0xB0.
  - Required: writes (0, 0x00100513) and (1, 0x00200593), each imem_we exactly 1 cycle.
  - Then done=1 and cpu_reset_n=1.
- Zero length:
  - Stimulus: start, 00 00, checksum 00.
  - Required: no imem_we, done=1.
- Checksum mismatch:
  - Stimulus: the two-word frame with checksum 0xB1.
  - Required: both words written, then error=1, cpu_reset_n stays 0, done=0.
- Oversize length with ADDR_W=10:
  - Stimulus: LEN = 01 04 (N=1025).
  - Required: error=1 immediately after LEN_HI; no imem_we; byte_ready=0 afterwards.
- Backpressure and ignored start:
  - Stimulus: two-word frame with byte_valid deasserted 3 random cycles between bytes, plus a start pulse during DATA.
  - Required: same writes as the two-word load; start has no effect.
- Reset mid-load:
  - Stimulus: reset_n low after 2 payload bytes, then a full new load.
  - Required: all outputs at reset values, no spurious write, new load completes with first write at address 0.
